level_tone_dac: RTL and testbench

//  Playback counterpart to the microphone level path: converts a 4-bit volume level (0..15) into a

---
 rtl/level_tone_dac_pkg.sv | 27 ++
 rtl/level_tone_dac_if.sv | 21 ++
 rtl/level_tone_dac_da2_spi_tx.sv | 83 ++++++++
 rtl/level_tone_dac.sv | 85 ++++++++
 tb/tb_level_tone_dac.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/level_tone_dac_pkg.sv
// Shared definitions for the level-to-tone DAC playback path: FSM encodings,
// DA2 frame constants and the amplitude arithmetic used to build a sample.
package level_tone_dac_pkg;

    // Serializer FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // DA2 converter constants
    localparam logic [11:0] DAC_MIDSCALE   = 12'd2048;
    localparam int          DA2_FRAME_BITS = 16;
    localparam logic [1:0]  DA2_PD_NORMAL  = 2'b00;

    // Mid-scale plus or minus the level scaled by 128; never wraps for a 4-bit level
    function automatic logic [11:0] toneSample(input logic [3:0] lvl, input logic pol);
        logic [11:0] swing;
        swing = {1'b0, lvl, 7'b0};
        return pol ? (DAC_MIDSCALE + swing) : (DAC_MIDSCALE - swing);
    endfunction

    // Two don't-care bits (driven zero), normal power-down mode, then the 12-bit sample
    function automatic logic [15:0] da2Word(input logic [11:0] sample);
        return {2'b00, DA2_PD_NORMAL, sample};
    endfunction

endpackage

// File: rtl/level_tone_dac_if.sv
// Bundle of the volume input and the DA2 pin/status outputs. The master side is
// the tone generator that drives the Pmod; the slave side is whoever watches it.
interface level_tone_dac_if;
    logic [3:0] level;
    logic       dac_sync_n;
    logic       dac_sclk;
    logic       dac_din;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    modport master (
        input  level,
        output dac_sync_n, dac_sclk, dac_din, busy, frame_done, overrun
    );

    modport slave (
        output level,
        input  dac_sync_n, dac_sclk, dac_din, busy, frame_done, overrun
    );
endinterface

// File: rtl/level_tone_dac_da2_spi_tx.sv
// Serializer for one 16-bit DA2 frame: SYNC_n low for 16 SCLK periods, data MSB
// first, changing on SCLK rising edges so the DAC can sample on falling edges.
module da2_spi_tx
    import level_tone_dac_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data,
    output logic        sync_n,
    output logic        sclk,
    output logic        din,
    output logic        busy,
    output logic        done
);

    localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DA2_FRAME_BITS - 1);

    logic [1:0]       r_state;
    logic [15:0]      r_shift;
    logic [3:0]       r_bitCnt;
    logic [DIV_W-1:0] r_divCnt;
    logic             r_sclk;

    // Frame sequencing: load on start, toggle SCLK every SCLK_DIV cycles, shift on rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_divCnt <= '0;
            r_sclk   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_SHIFT;
                        r_shift  <= data;
                        r_bitCnt <= '0;
                        r_divCnt <= '0;
                        r_sclk   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_divCnt == DIV_LAST) begin
                        r_divCnt <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            if (r_bitCnt != LAST_BIT) begin
                                r_shift <= {r_shift[14:0], 1'b0};
                            end
                        end else if (r_bitCnt == LAST_BIT) begin
                            r_state <= ST_DONE;
                            r_shift <= '0;
                        end else begin
                            r_sclk   <= 1'b0;
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sync_n = (r_state != ST_SHIFT);
    assign sclk   = r_sclk;
    assign din    = r_shift[15];
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

endmodule

// File: rtl/level_tone_dac.sv
// Converts a 4-bit volume level into a square-wave tone streamed to the Pmod DA2.
// Owns the sample-rate counter, tone phase/polarity, amplitude and overrun flag.
module level_tone_dac
    import level_tone_dac_pkg::*;
#(
    parameter int SAMPLE_DIV = 4000,
    parameter int SCLK_DIV   = 4,
    parameter int TONE_HALF  = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    level_tone_dac_if.master bus
);

    localparam int               CNT_W    = $clog2(SAMPLE_DIV);
    localparam int               PH_W     = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TONE_HALF - 1);

    logic [CNT_W-1:0] r_sampleCnt;
    logic [PH_W-1:0]  r_phase;
    logic             r_polarity;
    logic             r_overrun;
    logic             w_tick;
    logic             w_busy;
    logic             w_start;
    logic [15:0]      w_word;

    assign w_tick  = (r_sampleCnt == CNT_LAST);
    assign w_start = w_tick && !w_busy;
    assign w_word  = da2Word(toneSample(bus.level, r_polarity));

    // Free-running sample-rate counter, wraps every SAMPLE_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampleCnt <= '0;
        end else if (w_tick) begin
            r_sampleCnt <= '0;
        end else begin
            r_sampleCnt <= r_sampleCnt + 1'b1;
        end
    end

    // Tone phase advances only for samples actually sent; polarity flips every TONE_HALF samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_polarity <= 1'b1;
        end else if (w_start) begin
            if (r_phase == PH_LAST) begin
                r_phase    <= '0;
                r_polarity <= ~r_polarity;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // Sticky flag for a sample tick that found the serializer still busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_tick && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    da2_spi_tx #(
        .SCLK_DIV(SCLK_DIV)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .data   (w_word),
        .sync_n (bus.dac_sync_n),
        .sclk   (bus.dac_sclk),
        .din    (bus.dac_din),
        .busy   (w_busy),
        .done   (bus.frame_done)
    );

    assign bus.busy    = w_busy;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_level_tone_dac.sv
// Bench for level_tone_dac: a cycle-level arithmetic model of the frame timing
// and sample values, an independent frame decoder, and literal pins.
module tb_level_tone_dac;

    localparam int S_A  = 200;
    localparam int SCLK = 4;
    localparam int TH   = 25;
    localparam int S_B  = 100;
    localparam int FLEN = 32 * SCLK;

    logic clk   = 1'b0;
    logic rstA_n = 1'b1;
    logic rstB_n = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] capA[$];

    level_tone_dac_if busA();
    level_tone_dac_if busB();

    level_tone_dac #(.SAMPLE_DIV(S_A), .SCLK_DIV(SCLK), .TONE_HALF(TH)) dutA (
        .clk   (clk),
        .rst_n (rstA_n),
        .bus   (busA)
    );

    level_tone_dac #(.SAMPLE_DIV(S_B), .SCLK_DIV(SCLK), .TONE_HALF(TH)) dutB (
        .clk   (clk),
        .rst_n (rstB_n),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports the ones that fail
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Level changes land just after a rising edge so they never race the sample point
    task automatic applyStimulus(input logic [3:0] lvl);
        @(posedge clk);
        #2 busA.level = lvl;
    endtask

    task automatic resetA(input logic [3:0] lvl);
        @(posedge clk);
        #2 rstA_n = 1'b0;
        busA.level = lvl;
        repeat (3) @(negedge clk);
        capA.delete();
        #1 rstA_n = 1'b1;
    endtask

    task automatic waitFrames(input int n);
        int budget;
        budget = (n + 1) * S_A + 200;
        while (capA.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        vectors++;
        if (capA.size() < n) begin
            miscompares++;
            $display("[TB] FAIL frameWait: got %0d frames, expected %0d", capA.size(), n);
        end
    endtask

    function automatic logic [15:0] capAt(input int i);
        if (i < capA.size()) return capA[i];
        return 16'hxxxx;
    endfunction

    // Expected 16-bit frame for frame n at a given level: high half-cycle first
    function automatic logic [15:0] modelWord(input int n, input int lvl);
        int s;
        s = (((n / TH) % 2) == 0) ? (2048 + lvl * 128) : (2048 - lvl * 128);
        return 16'(s);
    endfunction

    // Per-cycle model of DUT A: frame n occupies cycles S_A*(n+1) .. S_A*(n+1)+FLEN after release
    int          mEdges;
    logic [15:0] mWord;
    always @(negedge clk) begin : compareA
        int m;
        int bitIdx;
        logic [5:0] expV;
        logic [5:0] actV;
        logic expSync, expSclk, expDin, expBusy, expDone, useDin;
        if (!rstA_n) begin
            mEdges = 0;
            actV = {busA.dac_sync_n, busA.dac_sclk, busA.dac_din, busA.busy, busA.frame_done, busA.overrun};
            checkOutput("resetA", 32'(actV), 32'(6'b110000));
        end else begin
            mEdges++;
            m = mEdges % S_A;
            expSync = 1'b1; expSclk = 1'b1; expDin = 1'b0;
            expBusy = 1'b0; expDone = 1'b0; useDin = 1'b0;
            if (mEdges >= S_A) begin
                if (m < FLEN) begin
                    expSync = 1'b0;
                    expBusy = 1'b1;
                    expSclk = ((m / SCLK) % 2) == 1;
                    bitIdx  = (m + SCLK) / (2 * SCLK);
                    if (bitIdx > 15) bitIdx = 15;
                    expDin  = mWord[15 - bitIdx];
                    useDin  = 1'b1;
                end else if (m == FLEN) begin
                    expBusy = 1'b1;
                    expDone = 1'b1;
                end
            end
            expV = {expSync, expSclk, useDin & expDin, expBusy, expDone, 1'b0};
            actV = {busA.dac_sync_n, busA.dac_sclk, useDin & busA.dac_din, busA.busy, busA.frame_done, busA.overrun};
            checkOutput("cycleA", 32'(actV), 32'(expV));
            if (((mEdges + 1) % S_A) == 0) begin
                mWord = modelWord((mEdges + 1) / S_A - 1, int'(busA.level));
            end
        end
    end

    // Independent decoder: shift din on each observed SCLK fall while SYNC_n is low
    logic        dPrevSync, dPrevSclk;
    logic [15:0] dBits;
    int          dCnt;
    always @(negedge clk) begin : decodeA
        if (!rstA_n) begin
            dPrevSync = 1'b1;
            dPrevSclk = 1'b1;
            dCnt = 0;
        end else begin
            if (!busA.dac_sync_n && dPrevSync) begin
                dCnt  = 0;
                dBits = '0;
            end
            if (!busA.dac_sync_n && dPrevSclk && !busA.dac_sclk) begin
                dBits = {dBits[14:0], busA.dac_din};
                dCnt++;
            end
            if (busA.dac_sync_n && !dPrevSync) begin
                checkOutput("sclkFalls", 32'(dCnt), 32'd16);
                capA.push_back(dBits);
            end
            dPrevSync = busA.dac_sync_n;
            dPrevSclk = busA.dac_sclk;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int c;
        busA.level = 4'd0;
        busB.level = 4'd5;
        #1;
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        repeat (3) @(negedge clk);

        // Silence: first frame exactly S_A cycles after release, every frame mid-scale
        #1 rstA_n = 1'b1;
        c = 0;
        while (busA.dac_sync_n && c < 1000) begin
            @(posedge clk);
            #1 c++;
        end
        checkOutput("firstFall", 32'(c), 32'(S_A));
        waitFrames(2 * TH);
        checkOutput("lvl0_f0",  32'(capAt(0)),  32'h0800);
        checkOutput("lvl0_f25", 32'(capAt(25)), 32'h0800);
        checkOutput("lvl0_f49", 32'(capAt(49)), 32'h0800);

        // Full swing: 25 frames high, 25 low, repeating
        resetA(4'd15);
        waitFrames(2 * TH + 1);
        checkOutput("lvl15_f0",  32'(capAt(0)),  32'h0F80);
        checkOutput("lvl15_f24", 32'(capAt(24)), 32'h0F80);
        checkOutput("lvl15_f25", 32'(capAt(25)), 32'h0080);
        checkOutput("lvl15_f49", 32'(capAt(49)), 32'h0080);
        checkOutput("lvl15_f50", 32'(capAt(50)), 32'h0F80);

        // Half swing, then a level step in the middle of a frame
        resetA(4'd8);
        waitFrames(TH + 1);
        checkOutput("lvl8_f0",  32'(capAt(0)),  32'h0C00);
        checkOutput("lvl8_f25", 32'(capAt(25)), 32'h0400);
        c = 0;
        while (busA.dac_sync_n && c < 2 * S_A) begin
            @(posedge clk);
            c++;
        end
        repeat (20) @(posedge clk);
        applyStimulus(4'd3);
        waitFrames(TH + 3);
        checkOutput("stepCur",  32'(capAt(26)), 32'h0400);
        checkOutput("stepNext", 32'(capAt(27)), 32'h0680);

        // Random levels at random moments, checked cycle by cycle against the model
        resetA(4'($urandom_range(0, 15)));
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(50, 400)) @(posedge clk);
            applyStimulus(4'($urandom_range(0, 15)));
        end

        // Asynchronous reset in the middle of a frame
        c = 0;
        while (busA.dac_sync_n && c < 2 * S_A) begin
            @(posedge clk);
            c++;
        end
        repeat (30) @(posedge clk);
        #2 rstA_n = 1'b0;
        #1;
        checkOutput("midRstSync", 32'(busA.dac_sync_n), 32'd1);
        checkOutput("midRstSclk", 32'(busA.dac_sclk),   32'd1);
        checkOutput("midRstBusy", 32'(busA.busy),       32'd0);
        repeat (3) @(negedge clk);

        // Short sample period: second tick lands inside the first frame
        #1 rstB_n = 1'b1;
        repeat (150) @(posedge clk);
        #1 checkOutput("ovrBefore", 32'(busB.overrun), 32'd0);
        repeat (60) @(posedge clk);
        #1 checkOutput("ovrAfter",  32'(busB.overrun), 32'd1);
        checkOutput("ovrBusy", 32'(busB.busy), 32'd1);
        #1 rstB_n = 1'b0;
        #1;
        checkOutput("ovrRstSync", 32'(busB.dac_sync_n), 32'd1);
        checkOutput("ovrRstSclk", 32'(busB.dac_sclk),   32'd1);
        checkOutput("ovrRstFlag", 32'(busB.overrun),    32'd0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
